// File: rtl/rx_control_module.sv
// UART receive frame controller: samples start, data, optional parity and stop
// bits on mid-bit strobes and delivers a byte with a done pulse and error flags.
module rx_control_module #(
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       RX_En_Sig,
    input  logic       H_L_Sig,
    input  logic       RX_Pin_In,
    input  logic       BPS_CLK,
    output logic       Count_Sig,
    output logic [7:0] RX_Data,
    output logic       RX_Done_Sig,
    output logic [1:0] RX_Err_Sig
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } state_t;

    state_t              state_q,   state_d;
    logic                count_q,   count_d;
    logic [DATA_W-1:0]   shift_q,   shift_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                perr_q,    perr_d;
    logic [DATA_W-1:0]   data_q,    data_d;
    logic                done_q,    done_d;
    logic [1:0]          err_q,     err_d;

    // State and output registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= ST_IDLE;
            count_q   <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            perr_q    <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            perr_q    <= perr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state and next-output logic; done and error flags are single-cycle
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        perr_d    = perr_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = 2'b00;

        if (!RX_En_Sig) begin
            // Disabling the receiver abandons any frame in flight
            state_d = ST_IDLE;
            count_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (H_L_Sig) begin
                        state_d   = ST_START;
                        count_d   = 1'b1;
                        perr_d    = 1'b0;
                        bit_cnt_d = '0;
                    end
                end
                ST_START: begin
                    if (BPS_CLK) begin
                        if (!RX_Pin_In) begin
                            state_d   = ST_DATA;
                            bit_cnt_d = '0;
                        end else begin
                            // Line back high at mid-start: treat as a glitch
                            state_d = ST_IDLE;
                            count_d = 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (BPS_CLK) begin
                        shift_d[bit_cnt_q] = RX_Pin_In;
                        bit_cnt_d          = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (BPS_CLK) begin
                        perr_d  = RX_Pin_In != ((^shift_q) ^ PARITY_ODD);
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (BPS_CLK) begin
                        state_d = ST_DONE;
                        count_d = 1'b0;
                        data_d  = shift_q;
                        done_d  = 1'b1;
                        err_d   = {perr_q & PARITY_EN, ~RX_Pin_In};
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = 1'b0;
                end
            endcase
        end
    end

    assign Count_Sig   = count_q;
    assign RX_Data     = data_q;
    assign RX_Done_Sig = done_q;
    assign RX_Err_Sig  = err_q;

endmodule

// File: tb/tb_rx_control_module.sv
// Bench for rx_control_module: one instance without parity, one with even parity,
// each fed by its own serial line, edge detector and scaled baud generator.
module tb_rx_control_module;

    localparam int BIT  = 16;
    localparam int HALF = 8;

    logic CLK;
    logic RSTn;
    logic rx [2];
    logic en [2];

    logic       cnt0, cnt1, done0, done1;
    logic [7:0] data0, data1;
    logic [1:0] err0, err1;

    logic [1:0]      rx_prev;
    logic [4:0]      bcnt [2];
    logic            hl0, hl1, bps0, bps1;
    logic [1:0]      o_cnt, o_done;
    logic [1:0][7:0] o_data;
    logic [1:0][1:0] o_err;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] last_data [2];

    rx_control_module #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
        .CLK(CLK), .RSTn(RSTn), .RX_En_Sig(en[0]), .H_L_Sig(hl0),
        .RX_Pin_In(rx[0]), .BPS_CLK(bps0), .Count_Sig(cnt0),
        .RX_Data(data0), .RX_Done_Sig(done0), .RX_Err_Sig(err0)
    );

    rx_control_module #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
        .CLK(CLK), .RSTn(RSTn), .RX_En_Sig(en[1]), .H_L_Sig(hl1),
        .RX_Pin_In(rx[1]), .BPS_CLK(bps1), .Count_Sig(cnt1),
        .RX_Data(data1), .RX_Done_Sig(done1), .RX_Err_Sig(err1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign o_cnt  = {cnt1, cnt0};
    assign o_done = {done1, done0};
    assign o_data = {data1, data0};
    assign o_err  = {err1, err0};

    // Falling-edge detectors and baud generators (first strobe half a bit after Count_Sig rises)
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rx_prev <= 2'b11;
            bcnt[0] <= '0;
            bcnt[1] <= '0;
        end else begin
            rx_prev <= {rx[1], rx[0]};
            for (int k = 0; k < 2; k++) begin
                if (!o_cnt[k])               bcnt[k] <= '0;
                else if (bcnt[k] == 5'(BIT - 1)) bcnt[k] <= '0;
                else                         bcnt[k] <= bcnt[k] + 5'd1;
            end
        end
    end

    assign hl0  = rx_prev[0] & ~rx[0];
    assign hl1  = rx_prev[1] & ~rx[1];
    assign bps0 = cnt0 && (bcnt[0] == 5'(HALF));
    assign bps1 = cnt1 && (bcnt[1] == 5'(HALF));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int k, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            rx[k] = 1'b1;
        end
    endtask

    // Drive one frame on line k; abort_at >= 0 drops enable mid-way through that line bit
    task automatic send_frame(input int k, input logic [7:0] d, input logic pb,
                              input logic sb, input int abort_at, input string tag);
        logic       bits [$];
        int         seen = 0;
        logic [7:0] cap_d = '0;
        logic [1:0] cap_e = '0;
        bit         exp_done;
        logic [1:0] exp_err;
        exp_done = (abort_at < 0);
        exp_err  = {(k == 1) && (($countones({d, pb}) % 2) != 0), ~sb};
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (k == 1) bits.push_back(pb);
        bits.push_back(sb);
        for (int j = 0; j < bits.size(); j++) begin
            for (int c = 0; c < BIT; c++) begin
                @(negedge CLK);
                if (c == 0) rx[k] = bits[j];
                if (j == abort_at && c == 4) en[k] = 1'b0;
                if (j == abort_at && c == 5) check({tag, " abort_cnt"}, 8'(o_cnt[k]), 8'h00);
                if (o_done[k]) begin
                    seen++;
                    cap_d = o_data[k];
                    cap_e = o_err[k];
                end
            end
        end
        en[k] = 1'b1;
        check({tag, " done_pulses"}, 8'(seen), 8'(exp_done));
        if (exp_done) begin
            check({tag, " data"}, cap_d, d);
            check({tag, " err"}, 8'(cap_e), 8'(exp_err));
            last_data[k] = d;
        end else begin
            check({tag, " data_held"}, o_data[k], last_data[k]);
        end
        check({tag, " cnt_after"}, 8'(o_cnt[k]), 8'h00);
        check({tag, " err_after"}, 8'(o_err[k]), 8'h00);
    endtask

    initial begin
        bit         hi;
        int         seen;
        int         k;
        int         gap;
        logic [7:0] d;
        logic       pb, sb;

        RSTn = 1'b0;
        rx[0] = 1'b1; rx[1] = 1'b1;
        en[0] = 1'b1; en[1] = 1'b1;
        last_data[0] = 8'h00; last_data[1] = 8'h00;
        repeat (5) @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            check("rst cnt",  8'(o_cnt[i]),  8'h00);
            check("rst data", o_data[i],     8'h00);
            check("rst done", 8'(o_done[i]), 8'h00);
            check("rst err",  8'(o_err[i]),  8'h00);
        end
        RSTn = 1'b1;
        idle(0, 5);

        send_frame(0, 8'h55, 1'b0, 1'b1, -1, "f55");
        idle(0, 3);
        send_frame(0, 8'hA3, 1'b0, 1'b1, -1, "b2b_a3");
        send_frame(0, 8'h0F, 1'b0, 1'b1, -1, "b2b_0f");
        idle(0, 3);

        // Short low glitch: Count_Sig rises, then the start sample sees high
        hi = 1'b0; seen = 0;
        @(negedge CLK); rx[0] = 1'b0;
        repeat (3) @(negedge CLK);
        @(negedge CLK); rx[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (o_cnt[0]) hi = 1'b1;
            if (o_done[0]) seen++;
        end
        check("glitch cnt_seen_high", 8'(hi), 8'h01);
        check("glitch done_pulses", 8'(seen), 8'h00);
        check("glitch cnt_after", 8'(o_cnt[0]), 8'h00);
        check("glitch data_held", o_data[0], last_data[0]);

        send_frame(0, 8'h81, 1'b0, 1'b0, -1, "ferr_81");
        idle(0, 5);
        send_frame(0, 8'h3C, 1'b0, 1'b1, -1, "ok_3c");
        idle(0, 3);

        send_frame(1, 8'h07, 1'b1, 1'b1, -1, "par_ok_07");
        idle(1, 3);
        send_frame(1, 8'h07, 1'b0, 1'b1, -1, "par_bad_07");
        idle(1, 3);

        // Edge while disabled must not start a frame
        hi = 1'b0;
        en[0] = 1'b0;
        @(negedge CLK); rx[0] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (o_cnt[0]) hi = 1'b1;
        end
        rx[0] = 1'b1;
        idle(0, 3);
        en[0] = 1'b1;
        check("dis_edge cnt_seen_high", 8'(hi), 8'h00);
        idle(0, 3);

        send_frame(0, 8'hFF, 1'b0, 1'b1, 5, "abort_ff");
        idle(0, 3);

        // Asynchronous reset in the middle of a frame
        @(negedge CLK); rx[0] = 1'b0;
        repeat (40) @(negedge CLK);
        RSTn = 1'b0;
        #1;
        check("midrst cnt",  8'(o_cnt[0]),  8'h00);
        check("midrst data", o_data[0],     8'h00);
        check("midrst done", 8'(o_done[0]), 8'h00);
        check("midrst err",  8'(o_err[0]),  8'h00);
        check("midrst data1", o_data[1],    8'h00);
        rx[0] = 1'b1;
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        last_data[0] = 8'h00; last_data[1] = 8'h00;
        idle(0, 5);
        send_frame(0, 8'h5A, 1'b0, 1'b1, -1, "post_rst_5a");
        idle(0, 3);

        // Random frames alternating between the two instances
        for (int i = 0; i < 12; i++) begin
            k  = i % 2;
            d  = 8'($urandom);
            pb = 1'($urandom);
            sb = ($urandom_range(3) != 0);
            send_frame(k, d, pb, sb, -1, $sformatf("rnd%0d", i));
            gap = int'($urandom_range(0, 6));
            if (!sb && gap < 2) gap = 2;
            idle(k, gap);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard bound on run length
    initial begin
        repeat (60000) @(posedge CLK);
        $display("FAIL watchdog expired: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
